alu_bist_controller: RTL and testbench

- Hardware initiator for the 8-bit ALU: performs the stimulus sweep in silicon, without a bench.
- Drives operands and every opcode 0..18 into an ALU instance.
- Samples ALU_Out/ALU_Carry after a settle window and compresses all results into a 16-bit MISR signature.
- Reports done and pass/fail against an expected signature; sits beside the ALU as a start/done power-on self-test engine.

---
 rtl/alu_bist_pkg.sv | 37 +++
 rtl/alu_bist_misr.sv | 40 ++++
 rtl/alu_bist_controller.sv | 200 ++++++++++++++++++++
 tb/tb_alu_bist_controller.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// alu_bist_pkg: shared definitions for the ALU built-in self-test engine.
//   - FSM state encoding for alu_bist_controller
//   - MISR polynomial/seed and the MISR update function
//   - operand LFSR tap mask and step function
//   - zero-seed substitute and default opcode count
package alu_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSample,
        StDone
    } bist_state_e;

    localparam int unsigned MISR_W          = 16;
    localparam int unsigned MISR_DATA_W     = 9;
    localparam logic [15:0] MISR_POLY       = 16'h1021;
    localparam logic [15:0] MISR_SEED       = 16'hFFFF;
    localparam logic [7:0]  LFSR_TAPS       = 8'hB8;  // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0]  ZERO_SEED_SUB   = 8'h01;
    localparam int unsigned NUM_OPS_DEFAULT = 19;

    // One MISR clock: shift left, fold the polynomial back in on a carry-out of bit 15,
    // then xor in the zero-extended {carry, result} sample.
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0]      s,
                                                    input logic [MISR_DATA_W-1:0] d);
        logic [MISR_W-1:0] fb;
        fb = s[MISR_W-1] ? MISR_POLY : '0;
        return {s[MISR_W-2:0], 1'b0} ^ fb ^ {{(MISR_W - MISR_DATA_W){1'b0}}, d};
    endfunction

    // Fibonacci LFSR step: feedback is the parity of the tapped bits (7, 5, 4, 3).
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// alu_bist_misr: 16-bit multiple-input signature register compacting ALU results.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset (state returns to MISR_SEED)
//   clr_i       reload the seed (has priority over en_i)
//   en_i        absorb data_i this cycle
//   data_i      {alu_carry, alu_out} sample
//   state_o     current signature
module alu_bist_misr
    import alu_bist_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [MISR_DATA_W-1:0] data_i,
    output logic [MISR_W-1:0]      state_o
);

    logic [MISR_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (clr_i) begin
            state_d = MISR_SEED;
        end else if (en_i) begin
            state_d = misr_step(state_q, data_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MISR_SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alu_bist_controller.sv
// alu_bist_controller: power-on self-test engine that sweeps every opcode of an 8-bit ALU
// over LFSR-generated operand pairs and compacts the results into a MISR signature.
// Ports:
//   clk, rst_n           clock / asynchronous active-low reset
//   start_i              level; accepted only while idle
//   seed_a_i, seed_b_i   initial operands (zero is replaced by 8'h01)
//   expected_sig_i       golden signature, compared on the last sample
//   alu_a_o/alu_b_o/alu_sel_o  registered ALU stimulus
//   alu_out_i, alu_carry_i     ALU response
//   busy_o               sweep in progress
//   done_o               one-cycle pulse at end of sweep
//   pass_o, signature_o  result, held until the next accepted start
// Optional build macro ALU_BIST_TRACE_EN adds trace_valid_o / trace_data_o, a registered
// {sel, a, b, out, carry} record emitted the cycle after every sample.
module alu_bist_controller
    import alu_bist_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SEL_W       = 5,
    parameter int unsigned NUM_OPS     = NUM_OPS_DEFAULT,
    parameter int unsigned NUM_VECTORS = 4,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned SIG_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [DATA_W-1:0]           seed_a_i,
    input  logic [DATA_W-1:0]           seed_b_i,
    input  logic [SIG_W-1:0]            expected_sig_i,
    output logic [DATA_W-1:0]           alu_a_o,
    output logic [DATA_W-1:0]           alu_b_o,
    output logic [SEL_W-1:0]            alu_sel_o,
    input  logic [DATA_W-1:0]           alu_out_i,
    input  logic                        alu_carry_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        pass_o,
    output logic [SIG_W-1:0]            signature_o
`ifdef ALU_BIST_TRACE_EN
    ,
    output logic                        trace_valid_o,
    output logic [2*DATA_W+SEL_W+DATA_W:0] trace_data_o
`endif
);

    localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned VEC_W    = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

    localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0]    LAST_SEL    = SEL_W'(NUM_OPS - 1);
    localparam logic [VEC_W-1:0]    LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    bist_state_e         state_q, state_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [SEL_W-1:0]    alu_sel_q, alu_sel_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [VEC_W-1:0]    vec_cnt_q, vec_cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [SIG_W-1:0]    sig_q, sig_d;

    logic                misr_clr;
    logic                misr_en;
    logic [SIG_W-1:0]    misr_state;

    alu_bist_misr u_misr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (misr_clr),
        .en_i    (misr_en),
        .data_i  ({alu_carry_i, alu_out_i}),
        .state_o (misr_state)
    );

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        settle_cnt_d = settle_cnt_q;
        vec_cnt_d    = vec_cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        sig_d        = sig_q;
        misr_clr     = 1'b0;
        misr_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    // An all-zero seed would lock the operand LFSR at zero.
                    alu_a_d      = (seed_a_i == '0) ? DATA_W'(ZERO_SEED_SUB) : seed_a_i;
                    alu_b_d      = (seed_b_i == '0) ? DATA_W'(ZERO_SEED_SUB) : seed_b_i;
                    alu_sel_d    = '0;
                    settle_cnt_d = '0;
                    vec_cnt_d    = '0;
                    busy_d       = 1'b1;
                    pass_d       = 1'b0;
                    sig_d        = '0;
                    misr_clr     = 1'b1;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (settle_cnt_q == LAST_SETTLE) begin
                    settle_cnt_d = '0;
                    state_d      = StSample;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            StSample: begin
                misr_en = 1'b1;
                if (alu_sel_q != LAST_SEL) begin
                    alu_sel_d = alu_sel_q + 1'b1;
                    state_d   = StSettle;
                end else if (vec_cnt_q != LAST_VEC) begin
                    alu_sel_d = '0;
                    vec_cnt_d = vec_cnt_q + 1'b1;
                    alu_a_d   = lfsr_step(alu_a_q);
                    alu_b_d   = lfsr_step(alu_b_q);
                    state_d   = StSettle;
                end else begin
                    // Capture the post-sample signature now so the result is visible in
                    // the same cycle as the done pulse.
                    sig_d   = misr_step(misr_state, {alu_carry_i, alu_out_i});
                    pass_d  = (sig_d == expected_sig_i);
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            settle_cnt_q <= '0;
            vec_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            sig_q        <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            settle_cnt_q <= settle_cnt_d;
            vec_cnt_q    <= vec_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            sig_q        <= sig_d;
        end
    end

    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_sel_o   = alu_sel_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign signature_o = sig_q;

`ifdef ALU_BIST_TRACE_EN
    logic                           trace_valid_q;
    logic [2*DATA_W+SEL_W+DATA_W:0] trace_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid_q <= 1'b0;
            trace_data_q  <= '0;
        end else begin
            trace_valid_q <= (state_q == StSample);
            if (state_q == StSample) begin
                trace_data_q <= {alu_sel_q, alu_a_q, alu_b_q, alu_out_i, alu_carry_i};
            end
        end
    end

    assign trace_valid_o = trace_valid_q;
    assign trace_data_o  = trace_data_q;
`endif

endmodule

// File: tb/tb_alu_bist_controller.sv
// tb_alu_bist_controller: self-checking bench for alu_bist_controller.
// A behavioural ALU drives the DUT's ALU inputs; a sweep-level model predicts every output
// from the cycle offset since the accepted start. Build with ALU_BIST_TRACE_EN to also
// check the trace port.
module tb_alu_bist_controller;

    localparam int NOPS = 19;
    localparam int NVEC = 4;
    localparam int SCYC = 2;
    localparam int T    = NVEC * NOPS * (SCYC + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  seed_a = 8'h00;
    logic [7:0]  seed_b = 8'h00;
    logic [15:0] expected_sig = 16'h0000;
    logic [7:0]  alu_a, alu_b, alu_out;
    logic [4:0]  alu_sel;
    logic        alu_carry, busy, done, pass;
    logic [15:0] signature;
    logic        fault_en = 1'b0;
    logic        chk_en = 1'b0;

    int n_vec = 0;
    int n_miss = 0;
    int cyc = 0;

`ifdef ALU_BIST_TRACE_EN
    logic        trace_valid;
    logic [29:0] trace_data;
`endif

    alu_bist_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .seed_a_i       (seed_a),
        .seed_b_i       (seed_b),
        .expected_sig_i (expected_sig),
        .alu_a_o        (alu_a),
        .alu_b_o        (alu_b),
        .alu_sel_o      (alu_sel),
        .alu_out_i      (alu_out),
        .alu_carry_i    (alu_carry),
        .busy_o         (busy),
        .done_o         (done),
        .pass_o         (pass),
        .signature_o    (signature)
`ifdef ALU_BIST_TRACE_EN
        ,
        .trace_valid_o  (trace_valid),
        .trace_data_o   (trace_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference functions ----------------
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [4:0] sel);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (sel)
            5'd0:    return {1'b0, a} + {1'b0, b};
            5'd1:    return {1'b0, a} - {1'b0, b};
            5'd2:    return {|p[15:8], p[7:0]};
            5'd3:    return (b == 8'h00) ? 9'h100 : {1'b0, a / b};
            5'd4:    return {a[7], a[6:0], 1'b0};
            5'd5:    return {a[0], 1'b0, a[7:1]};
            5'd6:    return {a[7], a[6:0], a[7]};
            5'd7:    return {a[0], a[0], a[7:1]};
            5'd8:    return {1'b0, a & b};
            5'd9:    return {1'b0, a | b};
            5'd10:   return {1'b0, a ^ b};
            5'd11:   return {1'b0, ~(a | b)};
            5'd12:   return {1'b0, ~(a & b)};
            5'd13:   return {1'b0, ~(a ^ b)};
            5'd14:   return {1'b0, 7'd0, (a > b)};
            5'd15:   return {1'b0, 7'd0, (a == b)};
            5'd16:   return {1'b0, a} + 9'd1;
            5'd17:   return {(a == 8'h00), a - 8'd1};
            5'd18:   return {1'b0, ~a};
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [8:0] alu_env(input logic [7:0] a, input logic [7:0] b,
                                           input logic [4:0] sel, input logic flt);
        logic [8:0] r;
        r = alu_f(a, b, sel);
        if (flt && sel == 5'd5) r[8] = 1'b0;
        return r;
    endfunction

    function automatic logic [7:0] lfsr(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    function automatic logic [7:0] lfsr_n(input logic [7:0] x, input int n);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < n; i++) v = lfsr(v);
        return v;
    endfunction

    function automatic logic [7:0] nz(input logic [7:0] x);
        return (x == 8'h00) ? 8'h01 : x;
    endfunction

    function automatic logic [15:0] compute_sig(input logic [7:0] sa, input logic [7:0] sb,
                                                input logic flt);
        logic [15:0] s;
        logic [7:0]  a, b;
        logic [8:0]  r;
        s = 16'hFFFF;
        a = sa;
        b = sb;
        for (int v = 0; v < NVEC; v++) begin
            for (int o = 0; o < NOPS; o++) begin
                r = alu_env(a, b, 5'(o), flt);
                s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {7'd0, r};
            end
            a = lfsr(a);
            b = lfsr(b);
        end
        return s;
    endfunction

    assign {alu_carry, alu_out} = alu_env(alu_a, alu_b, alu_sel, fault_en);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- sweep model ----------------
    // m_t: 0 = idle, 1..T = cycles of an active sweep, T+1 = done cycle.
    int          m_t = 0;
    logic [7:0]  m_sa = 8'h00, m_sb = 8'h00;
    logic [7:0]  h_a = 8'h00, h_b = 8'h00;
    logic [4:0]  h_sel = 5'd0;
    logic [15:0] h_sig = 16'h0000;
    logic        h_pass = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= 0;
            h_a    <= 8'h00;
            h_b    <= 8'h00;
            h_sel  <= 5'd0;
            h_sig  <= 16'h0000;
            h_pass <= 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t    <= 1;
                m_sa   <= nz(seed_a);
                m_sb   <= nz(seed_b);
                h_a    <= lfsr_n(nz(seed_a), NVEC - 1);
                h_b    <= lfsr_n(nz(seed_b), NVEC - 1);
                h_sel  <= 5'(NOPS - 1);
                h_sig  <= compute_sig(nz(seed_a), nz(seed_b), fault_en);
                h_pass <= (compute_sig(nz(seed_a), nz(seed_b), fault_en) == expected_sig);
            end
        end else if (m_t == T + 1) begin
            m_t <= 0;
        end else begin
            m_t <= m_t + 1;
        end
    end

    int          idx;
    logic [7:0]  ea, eb;
    logic [4:0]  esel;
    logic        ebusy, edone, epass;
    logic [15:0] esig;

    always @(negedge clk) begin
        if (chk_en) begin
            if (m_t >= 1 && m_t <= T) begin
                idx   = (m_t - 1) / (SCYC + 1);
                esel  = 5'(idx % NOPS);
                ea    = lfsr_n(m_sa, idx / NOPS);
                eb    = lfsr_n(m_sb, idx / NOPS);
                ebusy = 1'b1;
                edone = 1'b0;
                esig  = 16'h0000;
                epass = 1'b0;
            end else begin
                ea    = h_a;
                eb    = h_b;
                esel  = h_sel;
                ebusy = 1'b0;
                edone = (m_t == T + 1);
                esig  = h_sig;
                epass = h_pass;
            end
            chk("cyc_busy", busy, ebusy);
            chk("cyc_done", done, edone);
            chk("cyc_alu_a", alu_a, ea);
            chk("cyc_alu_b", alu_b, eb);
            chk("cyc_alu_sel", alu_sel, esel);
            chk("cyc_signature", signature, esig);
            chk("cyc_pass", pass, epass);
        end
    end

`ifdef ALU_BIST_TRACE_EN
    int          tr_cnt = 0;
    logic        tr_seen = 1'b0;
    logic [29:0] tr_first = 30'd0;
    always @(negedge clk) begin
        if (trace_valid) begin
            if (!tr_seen) tr_first <= trace_data;
            tr_seen <= 1'b1;
            tr_cnt  <= tr_cnt + 1;
        end
    end
`endif

    // ---------------- stimulus ----------------
    task automatic launch(input logic [7:0] sa, input logic [7:0] sb, input logic [15:0] es);
        seed_a       = sa;
        seed_b       = sb;
        expected_sig = es;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle; t counts cycles after the accepting edge.
    task automatic watch(input bit seq_mode, input bit zero_mode,
                         output int done_t, output int busy_n);
        done_t = -1;
        busy_n = 0;
        for (int t = 1; t <= T + 50; t++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (seq_mode && t == 4)  chk("seq_sel1", alu_sel, 5'd1);
            if (seq_mode && t == 57) chk("seq_sel18", alu_sel, 5'd18);
            if (seq_mode && t == 57) chk("seq_a_before", alu_a, 8'hC9);
            if (seq_mode && t == 58) chk("seq_sel0", alu_sel, 5'd0);
            if (seq_mode && t == 58) chk("seq_a_after", alu_a, 8'h92);
            if (zero_mode && t == 1) chk("zero_a", alu_a, 8'h01);
            if (zero_mode && t == 1) chk("zero_b", alu_b, 8'h01);
            if (zero_mode && t == 100) start = 1'b1;
            if (zero_mode && t == 103) start = 1'b0;
            if (done) begin
                done_t = t;
                break;
            end
        end
        if (done_t < 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] golden;
        int          dt, bn;
`ifdef ALU_BIST_TRACE_EN
        int          tr_before;
`endif
        golden = compute_sig(8'hC9, 8'hEC, 1'b0);

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sig", signature, 16'h0000);
        chk("rst_pass", pass, 1'b0);
        chk("rst_alu_a", alu_a, 8'h00);
        chk("rst_alu_sel", alu_sel, 5'd0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Golden sweep
`ifdef ALU_BIST_TRACE_EN
        tr_before = tr_cnt;
`endif
        launch(8'hC9, 8'hEC, golden);
        watch(1'b1, 1'b0, dt, bn);
        chk("golden_done_t", dt, T + 1);
        chk("golden_busy_n", bn, T);
        chk("golden_pass", pass, 1'b1);
        chk("golden_sig", signature, golden);
        @(posedge clk);
        #1;
`ifdef ALU_BIST_TRACE_EN
        chk("trace_count", tr_cnt - tr_before, 76);
        chk("trace_first", tr_first, {5'd0, 8'hC9, 8'hEC, 8'hB5, 1'b1});
`endif

        // Carry stuck at 0 on opcode 5
        fault_en = 1'b1;
        launch(8'hC9, 8'hEC, golden);
        watch(1'b0, 1'b0, dt, bn);
        chk("fault_done_t", dt, T + 1);
        chk("fault_pass", pass, 1'b0);
        chk("fault_sig_differs", (signature != golden), 1'b1);
        @(posedge clk);
        #1 fault_en = 1'b0;

        // Reset in the middle of a sweep
        launch(8'hC9, 8'hEC, golden);
        repeat (49) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_alu_a", alu_a, 8'h00);
        chk("abort_alu_sel", alu_sel, 5'd0);
        chk("abort_sig", signature, 16'h0000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        launch(8'hC9, 8'hEC, golden);
        watch(1'b0, 1'b0, dt, bn);
        chk("restart_done_t", dt, T + 1);
        chk("restart_pass", pass, 1'b1);
        @(posedge clk);
        #1;

        // Zero seeds, with a start pulse during the sweep
        launch(8'h00, 8'h00, compute_sig(8'h01, 8'h01, 1'b0));
        watch(1'b0, 1'b1, dt, bn);
        chk("zero_done_t", dt, T + 1);
        chk("zero_pass", pass, 1'b1);
        @(posedge clk);
        #1;

        // Start held high: next sweep begins right after the done cycle
        seed_a       = 8'h5A;
        seed_b       = 8'h3C;
        expected_sig = 16'h0000;
        start        = 1'b1;
        @(posedge clk);
        #1;
        watch(1'b0, 1'b0, dt, bn);
        chk("held_done_t", dt, T + 1);
        @(negedge clk);
        chk("held_idle_gap", busy, 1'b0);
        @(negedge clk);
        chk("held_restart", busy, 1'b1);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not finish");
    end

endmodule
